// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet controller: FSM encoding and
// the default start-of-frame marker.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CKSUM,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload register file: synchronous write, asynchronous read.
// Contents carry no reset; only bytes below pkt_len are meaningful.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_packet_ctrl.sv
// Frames the UART byte stream into SYNC/CMD/LEN/payload/CKSUM packets.
// Optional inter-byte timeout: define UART_PKT_TIMEOUT_EN.
module uart_packet_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 50000,
    localparam int        LW = $clog2(MAX_LEN + 1),
    localparam int        AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          pkt_valid,
    input  logic          pkt_ack,
    output logic [7:0]    pkt_cmd,
    output logic [LW-1:0] pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_len,
    output logic          err_cksum,
    output logic          err_timeout
);

    localparam logic [7:0] MAX_L8 = 8'(MAX_LEN);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_run;
    logic [7:0]    r_cmd;
    logic [7:0]    r_cksum;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic          r_err_len;
    logic          r_err_ck;
    logic          r_err_to;
    logic          w_acc;
    logic          w_we;
    logic          w_last;
    logic          w_err_len;
    logic          w_err_ck;
    logic          w_to_hit;

    // r_run holds rx_ready low until the first edge after reset release
    assign rx_ready = r_run & (r_state != ST_HOLD);
    assign w_acc    = rx_valid & rx_ready;
    assign w_last   = (r_idx == r_len - 1'b1);

`ifdef UART_PKT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        w_busy;

    assign w_busy = (r_state == ST_CMD) | (r_state == ST_LEN) |
                    (r_state == ST_DATA) | (r_state == ST_CKSUM);
    assign w_to_hit = w_busy & ~w_acc & (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (!w_busy || w_acc || w_to_hit) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    logic w_unused_to;

    assign w_to_hit    = 1'b0;
    assign w_unused_to = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_len   = 1'b0;
        w_err_ck    = 1'b0;
        w_we        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc && rx_data == SYNC_BYTE) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_acc) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_acc) begin
                    if (rx_data > MAX_L8) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (rx_data == 8'd0) begin
                        w_state_nxt = ST_CKSUM;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_acc) begin
                    w_we = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_CKSUM;
                    end
                end
            end
            ST_CKSUM: begin
                if (w_acc) begin
                    if (rx_data == r_cksum) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_err_ck    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (pkt_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_to_hit) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run     <= 1'b0;
            r_cmd     <= '0;
            r_cksum   <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_err_len <= 1'b0;
            r_err_ck  <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_err_len <= w_err_len;
            r_err_ck  <= w_err_ck;
            r_err_to  <= w_to_hit;
            if (w_acc) begin
                case (r_state)
                    ST_CMD: begin
                        r_cmd   <= rx_data;
                        r_cksum <= rx_data;
                    end
                    ST_LEN: begin
                        r_len   <= rx_data[LW-1:0];
                        r_cksum <= r_cksum ^ rx_data;
                        r_idx   <= '0;
                    end
                    ST_DATA: begin
                        r_cksum <= r_cksum ^ rx_data;
                        r_idx   <= r_idx + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx[AW-1:0]),
        .i_wdata (rx_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign pkt_valid   = (r_state == ST_HOLD);
    assign pkt_cmd     = r_cmd;
    assign pkt_len     = r_len;
    assign err_len     = r_err_len;
    assign err_cksum   = r_err_ck;
    assign err_timeout = r_err_to;

endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Scoreboard bench for uart_packet_ctrl: directed frames in,
// monitor pops expected packets/errors as the DUT presents them.
module tb_uart_packet_ctrl;

    typedef struct packed {
        logic [7:0]       cmd;
        logic [7:0]       len;
        logic [15:0][7:0] d;
    } pkt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       pkt_ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       rx_ready;
    logic       pkt_valid;
    logic [7:0] pkt_cmd;
    logic [4:0] pkt_len;
    logic [7:0] rd_data;
    logic       err_len;
    logic       err_cksum;
    logic       err_timeout;

    int   checks = 0;
    int   errors = 0;
    pkt_t exp_q[$];
    int   err_q[$];

    uart_packet_ctrl #(
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .pkt_valid   (pkt_valid),
        .pkt_ack     (pkt_ack),
        .pkt_cmd     (pkt_cmd),
        .pkt_len     (pkt_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_len     (err_len),
        .err_cksum   (err_cksum),
        .err_timeout (err_timeout)
    );

    always #20 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin : monitor
        pkt_t p;
        bit   seen;
        int   code;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (err_len || err_cksum || err_timeout) begin
                code = err_len ? 1 : (err_cksum ? 2 : 3);
                chk32("err_onehot",
                      $countones({err_len, err_cksum, err_timeout}), 1);
                if (err_q.size() == 0) begin
                    chk32("unexpected_err", code, 0);
                end else begin
                    chk32("err_code", code, err_q.pop_front());
                end
            end
            if (pkt_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk1("unexpected_pkt", 1'b1, 1'b0);
                end else begin
                    p = exp_q.pop_front();
                    chk8("pkt_cmd", pkt_cmd, p.cmd);
                    chk8("pkt_len", 8'(pkt_len), p.len);
                    for (int i = 0; i < int'(p.len); i++) begin
                        rd_addr = 4'(i);
                        #1;
                        chk8("rd_data", rd_data, p.d[i]);
                    end
                end
            end else if (!pkt_valid) begin
                seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk1("rx_ready_wait", 1'b0, 1'b1);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input pkt_t p, input logic [7:0] ck);
        send(8'hA5);
        send(p.cmd);
        send(p.len);
        for (int i = 0; i < int'(p.len); i++) begin
            send(p.d[i]);
        end
        send(ck);
    endtask

    task automatic latency_ack();
        @(negedge clk);
        chk1("pkt_latency", pkt_valid, 1'b1);
        repeat (2) @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        chk1("valid_drop", pkt_valid, 1'b0);
    endtask

    task automatic err_pulse(input int code);
        logic e;
        @(negedge clk);
        e = (code == 1) ? err_len : ((code == 2) ? err_cksum : err_timeout);
        chk1("err_pulse_on", e, 1'b1);
        chk1("no_valid_on_err", pkt_valid, 1'b0);
        @(negedge clk);
        e = (code == 1) ? err_len : ((code == 2) ? err_cksum : err_timeout);
        chk1("err_pulse_off", e, 1'b0);
    endtask

    initial begin : stim
        pkt_t p;
        pkt_t pb;
        int   n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_rx_ready", rx_ready, 1'b0);
        chk1("rst_pkt_valid", pkt_valid, 1'b0);
        chk8("rst_pkt_cmd", pkt_cmd, 8'h00);
        chk8("rst_pkt_len", 8'(pkt_len), 8'h00);
        chk1("rst_errs", err_len | err_cksum | err_timeout, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk1("ready_after_rst", rx_ready, 1'b1);

        p = '0; p.cmd = 8'h10; p.len = 8'd2;
        p.d[0] = 8'h11; p.d[1] = 8'h22;
        exp_q.push_back(p);
        send_pkt(p, 8'h21);
        latency_ack();

        send(8'h00);
        send(8'hFF);
        p = '0; p.cmd = 8'h07; p.len = 8'd0;
        exp_q.push_back(p);
        send_pkt(p, 8'h07);
        latency_ack();

        err_q.push_back(1);
        send(8'hA5); send(8'h01); send(8'h11);
        err_pulse(1);
        p = '0; p.cmd = 8'h55; p.len = 8'd16;
        for (int i = 0; i < 16; i++) p.d[i] = 8'(i);
        exp_q.push_back(p);
        send_pkt(p, 8'h45);
        latency_ack();

        err_q.push_back(2);
        send(8'hA5); send(8'h10); send(8'h01); send(8'h33); send(8'h00);
        err_pulse(2);

        p = '0; p.cmd = 8'h20; p.len = 8'd3;
        p.d[0] = 8'hAA; p.d[1] = 8'hBB; p.d[2] = 8'hCC;
        exp_q.push_back(p);
        send_pkt(p, 8'hFE);
        pb = '0; pb.cmd = 8'h30; pb.len = 8'd1; pb.d[0] = 8'hA5;
        exp_q.push_back(pb);
        fork
            send_pkt(pb, 8'h94);
            begin
                repeat (8) @(negedge clk);
                chk1("hold_stall", rx_ready, 1'b0);
                chk8("hold_cmd", pkt_cmd, 8'h20);
                chk8("hold_len", 8'(pkt_len), 8'd3);
                pkt_ack = 1'b1;
                @(negedge clk);
                pkt_ack = 1'b0;
            end
        join
        latency_ack();

        send(8'hA5); send(8'h40); send(8'h04); send(8'h11); send(8'h22);
        @(negedge clk);
        #5 reset = 1'b0;
        #1;
        chk1("midrst_ready", rx_ready, 1'b0);
        chk8("midrst_cmd", pkt_cmd, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        p = '0; p.cmd = 8'h40; p.len = 8'd1; p.d[0] = 8'h5A;
        exp_q.push_back(p);
        send_pkt(p, 8'h1B);
        latency_ack();

`ifdef UART_PKT_TIMEOUT_EN
        err_q.push_back(3);
        send(8'hA5); send(8'h60); send(8'h03);
        n = 0;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk32("timeout_cycle", n, 100);
        @(negedge clk);
        chk1("timeout_off", err_timeout, 1'b0);
        p = '0; p.cmd = 8'h60; p.len = 8'd3;
        p.d[0] = 8'h01; p.d[1] = 8'h02; p.d[2] = 8'h03;
        exp_q.push_back(p);
        send_pkt(p, 8'h63);
        latency_ack();
`else
        send(8'hA5); send(8'h60); send(8'h03);
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (err_timeout) n++;
        end
        chk32("no_timeout", n, 0);
        p = '0; p.cmd = 8'h60; p.len = 8'd3;
        p.d[0] = 8'h01; p.d[1] = 8'h02; p.d[2] = 8'h03;
        exp_q.push_back(p);
        send(8'h01); send(8'h02); send(8'h03); send(8'h63);
        latency_ack();
`endif

        repeat (5) @(negedge clk);
        chk32("exp_q_empty", exp_q.size(), 0);
        chk32("err_q_empty", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
